// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode codes, FSM encoding and step helper for iter_shifter
package shift_pkg;

    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_ROTR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Positions to shift this cycle: never more than the per-cycle limit
    function automatic int unsigned step_amt(input int unsigned step, input int unsigned rem);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift of 0..STEP positions (rotate path under SHIFT_ROTATE_EN)
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] dout
);

`ifdef SHIFT_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
`endif

    // Select the shifted value; SRA fill comes from the sign latched at capture
    always_comb begin
        dout = din << amt;
`ifdef SHIFT_ROTATE_EN
        dbl  = {din, din} >> amt;
`endif
        case (mode)
            SHIFT_SRL: dout = din >> amt;
            SHIFT_SRA: dout = (din >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : '0);
`ifdef SHIFT_ROTATE_EN
            SHIFT_ROTR: dout = dbl[WIDTH-1:0];
`endif
            default:   dout = din << amt;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA shifter, rotate-right when SHIFT_ROTATE_EN is defined
module iter_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STEP    = 4,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    localparam int unsigned AMT_W = $clog2(STEP) + 1;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] rem_nx;
    logic [1:0]         mode_q;
    logic [1:0]         mode_dec;
    logic               sign_q;
    logic [AMT_W-1:0]   k;
    logic               accept;
    logic               last;

    // A new request is only taken when no shift is running (IDLE or DONE)
    assign accept = start && (state != ST_SHIFT);
    assign k      = AMT_W'(step_amt(STEP, 32'(rem)));
    assign rem_nx = rem - SHAMT_W'(k);
    assign last   = (rem_nx == '0);

`ifdef SHIFT_ROTATE_EN
    assign mode_dec = mode;
`else
    assign mode_dec = (mode == SHIFT_ROTR) ? SHIFT_SLL : mode;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .din  (work),
        .amt  (k),
        .mode (mode_q),
        .sign (sign_q),
        .dout (step_out)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; DONE accepts a start exactly like IDLE
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = (shamt == '0) ? ST_DONE : ST_SHIFT;
                else       state_nx = ST_IDLE;
            end
            ST_SHIFT: state_nx = last ? ST_DONE : ST_SHIFT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    // Work register, remaining count and result; data_out only sees final values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            rem      <= '0;
            mode_q   <= SHIFT_SLL;
            sign_q   <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            work   <= data_in;
            rem    <= shamt;
            mode_q <= mode_dec;
            sign_q <= data_in[WIDTH-1];
            if (shamt == '0) data_out <= data_in;
        end else if (state == ST_SHIFT) begin
            work <= step_out;
            rem  <= rem_nx;
            if (last) data_out <= step_out;
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter (model honours SHIFT_ROTATE_EN)
module tb_iter_shifter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    exp_t        q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input int s);
        logic [31:0] r;
        case (m)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $signed(d) >>> s;
            default: begin
`ifdef SHIFT_ROTATE_EN
                r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`else
                r = d << s;
`endif
            end
        endcase
        return r;
    endfunction

    // Drive a request at the current negedge and record what must come back
    task automatic issue(input logic [1:0] m, input logic [31:0] d, input int s);
        exp_t e;
        start   = 1'b1;
        mode    = m;
        data_in = d;
        shamt   = 5'(s);
        e.data  = model(m, d, s);
        e.cyc   = cyc + ((s == 0) ? 1 : ((s + 3) / 4 + 1));
        last_res = e.data;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step until done is seen; optionally poke start while busy to prove it is ignored
    task automatic wait_done(input bit noise);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) return;
            if (noise && busy && ($urandom_range(0, 2) == 0)) begin
                start   = 1'b1;
                mode    = 2'($urandom_range(0, 3));
                data_in = $urandom;
                shamt   = 5'($urandom_range(0, 31));
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", data_out, e.data);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", data_out, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // SLL by 2: one busy cycle then done
        issue(2'b00, 32'h1, 2);
        tick();
        chk("sll2_busy", 32'(busy), 32'd1);
        wait_done(1'b0);
        tick();
        chk("held_after_idle", data_out, 32'h4);

        // SRA / SRL of the MSB by the maximum amount
        issue(2'b10, 32'h8000_0000, 31);
        wait_done(1'b0);
        tick();
        issue(2'b01, 32'h8000_0000, 31);
        wait_done(1'b0);
        tick();

        // Zero shift amount in every mode
        for (int m = 0; m < 4; m++) begin
            issue(2'(m), 32'h1234_5678, 0);
            tick();
            chk("zero_busy", 32'(busy), 32'd0);
        end
        tick();

        // Ignored start mid-run, then back-to-back from DONE
        issue(2'b00, 32'h1, 8);
        tick();
        start = 1'b1; mode = 2'b00; data_in = 32'hFFFF; shamt = 5'd4;
        wait_done(1'b0);
        issue(2'b01, 32'h100, 4);
        wait_done(1'b0);
        tick();
        chk("b2b_result", data_out, 32'h10);

        // Reset in the middle of a shift
        issue(2'b01, 32'hF000_0000, 20);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_data", data_out, 32'd0);
        q.delete();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        issue(2'b00, 32'h3, 1);
        wait_done(1'b0);
        tick();

        // Mode 11 on 0xF by 4
        issue(2'b11, 32'hF, 4);
        wait_done(1'b0);
        tick();

        // Random operations, mixing idle gaps, back-to-back and ignored starts
        for (int n = 0; n < 200; n++) begin
            issue(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)));
            wait_done(1'b1);
            if ($urandom_range(0, 1) == 0) begin
                tick();
                chk("held_data", data_out, last_res);
            end
        end

        for (int i = 0; i < 12; i++) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
